instruction_fetch_dualpe: RTL and testbench

INSTRUCTION_FETCH_DUALPE -- requirements
Module: instruction_fetch_dualpe

---
 rtl/instruction_fetch_dualpe.sv | 170 +++++++++++++++++
 tb/tb_instruction_fetch_dualpe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_dualpe.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_dualpe
// Description : Dual-PE instruction fetch. Two identical, independent
//               channels, each with a fetch PC, a 2-entry {pc, instr} queue
//               with valid/ready delivery, RUN/HALT control, redirect and a
//               saturating delivered-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================

// One fetch channel: fetch PC, 2-deep queue, RUN/HALT FSM, delivery counter.
module instruction_fetch_channel #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'h0000_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] A,
    input  logic [31:0] RD,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid,
    input  logic        ready,
    output logic        halted,
    output logic [15:0] fcnt
);

    localparam logic [0:0]  S_RUN  = 1'b0;
    localparam logic [0:0]  S_HALT = 1'b1;
    localparam logic [15:0] c_fcnt_max = 16'hFFFF;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic        w_run;
    logic        w_halted;
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_count;
    logic [31:0] r_pc0, r_pc1, r_in0, r_in1;
    logic [15:0] r_fcnt;
    logic        w_pop;
    logic        w_fetch;
    logic        w_is_halt;
    logic [1:0]  w_slot;
    logic [31:0] w_redir_target;

    // Head entry pops on handshake; a fetch needs RUN, no redirect, and a free
    // slot either already present or created by this cycle's pop.
    assign w_pop          = (r_count != 2'd0) && ready;
    assign w_fetch        = w_run && !redir_valid && ((r_count != 2'd2) || w_pop);
    assign w_is_halt      = (RD == HALT_WORD);
    assign w_slot         = r_count - {1'b0, w_pop};
    assign w_redir_target = redir_pc & ~32'h0000_0003;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: a fetched halt word stops fetch; a redirect resumes it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (w_fetch && w_is_halt) w_state_nxt = S_HALT;
            S_HALT:  if (redir_valid)          w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_run    = (r_state == S_RUN);
        w_halted = (r_state == S_HALT);
    end

    // Fetch PC, queue storage and delivery counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= 2'd0;
            r_pc0      <= 32'h0;
            r_pc1      <= 32'h0;
            r_in0      <= 32'h0;
            r_in1      <= 32'h0;
            r_fcnt     <= 16'h0;
        end else begin
            if (w_pop && (r_fcnt != c_fcnt_max))
                r_fcnt <= r_fcnt + 16'd1;
            if (redir_valid) begin
                r_count    <= 2'd0;
                r_fetch_pc <= w_redir_target;
            end else begin
                r_count <= r_count - {1'b0, w_pop} + {1'b0, w_fetch};
                if (w_pop) begin
                    r_pc0 <= r_pc1;
                    r_in0 <= r_in1;
                end
                if (w_fetch) begin
                    // Push lands in the first slot free after any pop.
                    if (w_slot == 2'd0) begin
                        r_pc0 <= r_fetch_pc;
                        r_in0 <= RD;
                    end else begin
                        r_pc1 <= r_fetch_pc;
                        r_in1 <= RD;
                    end
                    // Halt word parks the PC on itself.
                    if (!w_is_halt)
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                end
            end
        end
    end

    assign A      = r_fetch_pc;
    assign instr  = r_in0;
    assign pc     = r_pc0;
    assign valid  = (r_count != 2'd0);
    assign halted = w_halted;
    assign fcnt   = r_fcnt;

endmodule

module instruction_fetch_dualpe #(
    parameter logic [31:0] RESET_PC1 = 32'h0000_0000,
    parameter logic [31:0] RESET_PC2 = 32'h0000_0800,
    parameter logic [31:0] HALT_WORD = 32'h0000_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] A1,
    output logic [31:0] A2,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    input  logic        redir1_valid,
    input  logic        redir2_valid,
    input  logic [31:0] redir1_pc,
    input  logic [31:0] redir2_pc,
    output logic [31:0] instr1,
    output logic [31:0] instr2,
    output logic [31:0] pc1,
    output logic [31:0] pc2,
    output logic        valid1,
    output logic        valid2,
    input  logic        ready1,
    input  logic        ready2,
    output logic        halted1,
    output logic        halted2,
    output logic [15:0] fcnt1,
    output logic [15:0] fcnt2
);

    instruction_fetch_channel #(.RESET_PC(RESET_PC1), .HALT_WORD(HALT_WORD)) u_ch1 (
        .clk(clk), .rst(rst), .A(A1), .RD(RD1),
        .redir_valid(redir1_valid), .redir_pc(redir1_pc),
        .instr(instr1), .pc(pc1), .valid(valid1), .ready(ready1),
        .halted(halted1), .fcnt(fcnt1)
    );

    instruction_fetch_channel #(.RESET_PC(RESET_PC2), .HALT_WORD(HALT_WORD)) u_ch2 (
        .clk(clk), .rst(rst), .A(A2), .RD(RD2),
        .redir_valid(redir2_valid), .redir_pc(redir2_pc),
        .instr(instr2), .pc(pc2), .valid(valid2), .ready(ready2),
        .halted(halted2), .fcnt(fcnt2)
    );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_dualpe.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_dualpe
// Description : Self-checking bench: directed scenarios plus random traffic,
//               compared every cycle against a queue-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_dualpe;

    localparam logic [31:0] c_halt = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_en;
    logic        rdy [2];
    logic        rv  [2];
    logic [31:0] rpc [2];
    logic [31:0] a_o [2];
    logic [31:0] rd  [2];
    logic [31:0] instr_o [2];
    logic [31:0] pc_o [2];
    logic        valid_o [2];
    logic        halted_o [2];
    logic [15:0] fcnt_o [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc   [2];
    logic        m_halt [2];
    logic [15:0] m_fcnt [2];
    int          m_cnt  [2];
    logic [31:0] m_epc  [2][2];
    logic [31:0] m_ein  [2][2];
    bit          m_was_rst;

    always #5 clk = ~clk;

    // Memory: word index of the address, with optional halt words planted
    // at every address whose bits [5:2] equal 4 (0x10, 0x50, ...).
    function automatic logic [31:0] memf(input logic [31:0] a, input logic he);
        if (he && a[5:2] == 4'd4) return c_halt;
        return {2'b00, a[31:2]};
    endfunction

    assign rd[0] = memf(a_o[0], halt_en);
    assign rd[1] = memf(a_o[1], halt_en);

    instruction_fetch_dualpe dut (
        .clk(clk), .rst(rst),
        .A1(a_o[0]), .A2(a_o[1]), .RD1(rd[0]), .RD2(rd[1]),
        .redir1_valid(rv[0]), .redir2_valid(rv[1]),
        .redir1_pc(rpc[0]), .redir2_pc(rpc[1]),
        .instr1(instr_o[0]), .instr2(instr_o[1]),
        .pc1(pc_o[0]), .pc2(pc_o[1]),
        .valid1(valid_o[0]), .valid2(valid_o[1]),
        .ready1(rdy[0]), .ready2(rdy[1]),
        .halted1(halted_o[0]), .halted2(halted_o[1]),
        .fcnt1(fcnt_o[0]), .fcnt2(fcnt_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_pc[c]   = (c == 0) ? 32'h0000_0000 : 32'h0000_0800;
                m_halt[c] = 1'b0;
                m_fcnt[c] = 16'h0;
                m_cnt[c]  = 0;
            end else begin
                bit          pop;
                bit          room;
                logic [31:0] w;
                pop  = (m_cnt[c] > 0) && rdy[c];
                room = (m_cnt[c] < 2) || pop;
                if (pop && m_fcnt[c] != 16'hFFFF) m_fcnt[c] = m_fcnt[c] + 16'd1;
                if (rv[c]) begin
                    m_cnt[c]  = 0;
                    m_pc[c]   = {rpc[c][31:2], 2'b00};
                    m_halt[c] = 1'b0;
                end else begin
                    if (pop) begin
                        m_epc[c][0] = m_epc[c][1];
                        m_ein[c][0] = m_ein[c][1];
                        m_cnt[c]    = m_cnt[c] - 1;
                    end
                    if (!m_halt[c] && room) begin
                        w = memf(m_pc[c], halt_en);
                        m_epc[c][m_cnt[c]] = m_pc[c];
                        m_ein[c][m_cnt[c]] = w;
                        m_cnt[c] = m_cnt[c] + 1;
                        if (w == c_halt) m_halt[c] = 1'b1;
                        else             m_pc[c]   = m_pc[c] + 32'd4;
                    end
                end
            end
        end
        m_was_rst = rst;
    endtask

    task automatic compare();
        for (int c = 0; c < 2; c++) begin
            check($sformatf("A%0d", c + 1), a_o[c], m_pc[c]);
            check($sformatf("valid%0d", c + 1), {31'b0, valid_o[c]}, {31'b0, m_cnt[c] != 0});
            check($sformatf("halted%0d", c + 1), {31'b0, halted_o[c]}, {31'b0, m_halt[c]});
            check($sformatf("fcnt%0d", c + 1), {16'b0, fcnt_o[c]}, {16'b0, m_fcnt[c]});
            if (m_cnt[c] != 0) begin
                check($sformatf("instr%0d", c + 1), instr_o[c], m_ein[c][0]);
                check($sformatf("pc%0d", c + 1), pc_o[c], m_epc[c][0]);
            end
            if (m_was_rst) begin
                check($sformatf("rst_instr%0d", c + 1), instr_o[c], 32'h0);
                check($sformatf("rst_pc%0d", c + 1), pc_o[c], 32'h0);
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            rdy[c] = 1'b0;
            rv[c]  = 1'b0;
            rpc[c] = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        halt_en = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // Streaming with ready held high
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        check("stream_fcnt1", {16'b0, fcnt_o[0]}, 32'd5);

        // Stall: queue fills, A1 parks at 0x8, then back-to-back delivery
        do_reset();
        rdy[0] = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check("stall_A1", a_o[0], 32'h8);
        check("stall_instr1", instr_o[0], 32'h0);
        rdy[0] = 1'b1;
        cycle();
        check("drain_pc1_a", pc_o[0], 32'h4);
        cycle();
        check("drain_pc1_b", pc_o[0], 32'h8);

        // Redirect with full queue and a simultaneous pop
        do_reset();
        rdy[0] = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rdy[0] = 1'b1; rv[0] = 1'b1; rpc[0] = 32'h0000_0043;
        cycle();
        check("redir_valid1", {31'b0, valid_o[0]}, 32'd0);
        check("redir_A1", a_o[0], 32'h40);
        check("redir_fcnt1", {16'b0, fcnt_o[0]}, 32'd1);
        rv[0] = 1'b0;
        cycle();
        check("redir_pc1", pc_o[0], 32'h40);

        // Halt word at 0x10, then redirect out of HALT
        halt_en = 1'b1;
        do_reset();
        rdy[0] = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check("halt_flag1", {31'b0, halted_o[0]}, 32'd1);
        check("halt_A1", a_o[0], 32'h10);
        check("halt_fcnt1", {16'b0, fcnt_o[0]}, 32'd5);
        rv[0] = 1'b1; rpc[0] = 32'h20;
        cycle();
        rv[0] = 1'b0;
        check("unhalt1", {31'b0, halted_o[0]}, 32'd0);
        for (int i = 0; i < 3; i++) cycle();

        // PE2 wrap-around while PE1 is stalled
        rdy[0] = 1'b0; rdy[1] = 1'b1;
        rv[1] = 1'b1; rpc[1] = 32'hFFFF_FFFC;
        cycle();
        rv[1] = 1'b0;
        cycle();
        check("wrap_pc2_a", pc_o[1], 32'hFFFF_FFFC);
        cycle();
        check("wrap_pc2_b", pc_o[1], 32'h0);

        // Reset with both queues holding entries
        rdy[1] = 1'b0;
        cycle();
        cycle();
        do_reset();
        check("rst_valid1", {31'b0, valid_o[0]}, 32'd0);
        check("rst_A2", a_o[1], 32'h800);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 2; c++) begin
                rdy[c] = ($urandom_range(0, 3) != 0);
                rv[c]  = ($urandom_range(0, 15) == 0);
                rpc[c] = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            end
            rst = ($urandom_range(0, 79) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
